motion_sequencer: RTL and testbench
===================================

MOTION_SEQUENCER -- requirements
Module: motion_sequencer

Interface
REQ-001 Parameter FWD_CYCLES, default 4, number of cycles motor_fwd is held per forward command (legal 1..255).
REQ-002 Parameter ROT_CYCLES, default 6, number of cycles motor_rot is held per rotate command (legal 1..255).
REQ-003 Parameter TRAP_LIMIT, default 4, consecutive completed rotations that declare the robot trapped (legal 1..15).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  decision FSM presents a command.
REQ-007 cmd_front  in  1  command requests forward motion.
REQ-008 cmd_rotate  in  1  command requests rotation.
REQ-009 clear_trap  in  1  operator pulse to leave TRAPPED.
REQ-010 cmd_ready  out  1  sequencer accepts a command this cycle.
REQ-011 motor_fwd  out  1  forward motor drive.
REQ-012 motor_rot  out  1  rotation motor drive.
REQ-013 trapped  out  1  trap condition latched.
REQ-014 step_count  out  8  completed forward moves, saturating.

Function
REQ-015 States SHALL be IDLE, FWD, ROT, TRAPPED; all outputs SHALL be registered (Moore), decoded from state and registers only.
REQ-016 cmd_ready SHALL be 1 exactly when state is IDLE; a command is accepted on an edge where cmd_valid and cmd_ready are both 1.
REQ-017 Accepted command with cmd_rotate=1 SHALL go to ROT, regardless of cmd_front (rotate has priority).
REQ-018 Accepted command with cmd_front=1, cmd_rotate=0 SHALL go to FWD.
REQ-019 Accepted command with both 0 SHALL be consumed, state remains IDLE, rotation streak unchanged.
REQ-020 Command accepted at edge N SHALL assert the motor output from cycle N+1 for exactly FWD_CYCLES (FWD) or ROT_CYCLES (ROT) cycles; cmd_ready SHALL return to 1 in the cycle after the last motor cycle.
REQ-021 motor_fwd and motor_rot SHALL never be 1 simultaneously; both 0 in IDLE and TRAPPED.
REQ-022 Completion of FWD SHALL clear the rotation streak to 0 and increment step_count, holding at 255 (no wrap).
REQ-023 Completion of ROT SHALL increment the 4-bit rotation streak; if the new value equals TRAP_LIMIT, next state SHALL be TRAPPED, else IDLE.
REQ-024 In TRAPPED: trapped=1, cmd_ready=0; cmd_valid ignored.
REQ-025 clear_trap=1 in TRAPPED SHALL move to IDLE next cycle with streak cleared; step_count unchanged; clear_trap SHALL be ignored in any other state.
REQ-026 clear_trap and cmd_valid in the same TRAPPED cycle: clear wins, command not accepted.
REQ-027 Input changes during FWD/ROT SHALL not alter the running motion or its duration.

Reset
REQ-028 reset=1 at an edge SHALL force state IDLE, streak 0, step_count 0, motor_fwd 0, motor_rot 0, trapped 0, cmd_ready 1 in the following cycle.
REQ-029 reset SHALL take priority over every other input, including mid-motion and in TRAPPED; the interrupted motion is abandoned, not counted.

Structure
REQ-030 Shared package robot_pkg SHALL hold the state encoding and the default FWD_CYCLES, ROT_CYCLES, TRAP_LIMIT constants.
REQ-031 One sub-module, cycle_timer (loadable down-counter with done flag, sync reset), SHALL time motor durations; everything else inline.

Verification (defaults 4/6/4)
REQ-032 Reset, then cmd_valid with front=1, rotate=0 accepted at edge N -> motor_fwd=1 cycles N+1..N+4, cmd_ready=1 at N+5, step_count=1.
REQ-033 front=1, rotate=1 accepted -> motor_rot=1 for exactly 6 cycles, motor_fwd stays 0, step_count unchanged.
REQ-034 Four rotate commands back to back -> trapped=1 after 4th ROT completes, cmd_ready=0; fifth cmd_valid ignored; clear_trap+cmd_valid same cycle -> IDLE next cycle, command not taken.
REQ-035 Three rotates, one forward, three rotates -> trapped stays 0 (streak cleared by forward).
REQ-036 reset asserted in 2nd cycle of FWD -> motor_fwd=0, cmd_ready=1 next cycle, step_count=0.
REQ-037 260 forward commands -> step_count saturates at 255; command with both 0 -> no motor activity, cmd_ready stays 1.

Source files
------------

// File: rtl/robot_pkg.sv
// Shared definitions for the motion sequencer: state encoding, default
// motion lengths and trap threshold, and a saturating counter helper.
package robot_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FWD     = 2'd1,
    ROT     = 2'd2,
    TRAPPED = 2'd3
  } state_t;

  localparam int DEF_FWD_CYCLES = 4;
  localparam int DEF_ROT_CYCLES = 6;
  localparam int DEF_TRAP_LIMIT = 4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; done is high during the last counted cycle so the
// owner can leave its timed state on the same edge the count expires.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/motion_sequencer.sv
// Turns accepted motion commands into timed motor pulses, counts forward
// steps and latches a trap condition after too many consecutive rotations.
module motion_sequencer #(
  parameter int FWD_CYCLES = robot_pkg::DEF_FWD_CYCLES,
  parameter int ROT_CYCLES = robot_pkg::DEF_ROT_CYCLES,
  parameter int TRAP_LIMIT = robot_pkg::DEF_TRAP_LIMIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic       cmd_front,
  input  logic       cmd_rotate,
  input  logic       clear_trap,
  output logic       cmd_ready,
  output logic       motor_fwd,
  output logic       motor_rot,
  output logic       trapped,
  output logic [7:0] step_count
);

  import robot_pkg::*;

  localparam logic [7:0] FWD_LEN  = 8'(FWD_CYCLES);
  localparam logic [7:0] ROT_LEN  = 8'(ROT_CYCLES);
  localparam logic [3:0] TRAP_LIM = 4'(TRAP_LIMIT);

  state_t     state, next_state;
  logic [3:0] streak;
  logic [3:0] streak_inc;
  logic [7:0] steps;
  logic       timer_load;
  logic [7:0] timer_value;
  logic       timer_done;
  logic       fwd_done;
  logic       rot_done;
  logic       trap_clear;

  cycle_timer #(.W(8)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  assign streak_inc = streak + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Handshake: a command transfers on any rising edge where cmd_valid and
  // cmd_ready are both 1; cmd_ready is 1 only in IDLE, so inputs seen in
  // FWD, ROT or TRAPPED never disturb a running motion.
  always_comb begin
    next_state  = state;
    timer_load  = 1'b0;
    timer_value = '0;
    fwd_done    = 1'b0;
    rot_done    = 1'b0;
    trap_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_rotate) begin
            next_state  = ROT;
            timer_load  = 1'b1;
            timer_value = ROT_LEN;
          end else if (cmd_front) begin
            next_state  = FWD;
            timer_load  = 1'b1;
            timer_value = FWD_LEN;
          end
        end
      end
      FWD: begin
        if (timer_done) begin
          next_state = IDLE;
          fwd_done   = 1'b1;
        end
      end
      ROT: begin
        if (timer_done) begin
          rot_done   = 1'b1;
          next_state = (streak_inc == TRAP_LIM) ? TRAPPED : IDLE;
        end
      end
      TRAPPED: begin
        if (clear_trap) begin
          next_state = IDLE;
          trap_clear = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Only completed motions update the counters; a reset mid-motion drops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= '0;
      steps  <= '0;
    end else if (fwd_done) begin
      streak <= '0;
      steps  <= sat_inc8(steps);
    end else if (rot_done) begin
      streak <= streak_inc;
    end else if (trap_clear) begin
      streak <= '0;
    end
  end

  assign cmd_ready  = (state == IDLE);
  assign motor_fwd  = (state == FWD);
  assign motor_rot  = (state == ROT);
  assign trapped    = (state == TRAPPED);
  assign step_count = steps;

endmodule

// File: tb/tb_motion_sequencer.sv
// Bench for motion_sequencer at default parameters: a command table, hand
// sequences for trap/clear and reset-in-motion, and step saturation.
module tb_motion_sequencer;

  localparam int FWD_LEN = 4;
  localparam int ROT_LEN = 6;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_front = 1'b0;
  logic cmd_rotate = 1'b0;
  logic clear_trap = 1'b0;
  logic cmd_ready, motor_fwd, motor_rot, trapped;
  logic [7:0] step_count;

  always #5 clk = ~clk;

  motion_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_front  (cmd_front),
    .cmd_rotate (cmd_rotate),
    .clear_trap (clear_trap),
    .cmd_ready  (cmd_ready),
    .motor_fwd  (motor_fwd),
    .motor_rot  (motor_rot),
    .trapped    (trapped),
    .step_count (step_count)
  );

  // scoreboard: one entry per cycle {motor_fwd, motor_rot, cmd_ready, trapped, step_count}
  logic [11:0] exp_q[$];
  logic [11:0] mon_exp, mon_got;
  int total = 0;
  int bad = 0;
  string cur_name = "reset";

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = {motor_fwd, motor_rot, cmd_ready, trapped, step_count};
      total++;
      if (mon_got !== mon_exp) begin
        bad++;
        $display("FAIL %s t=%0t: got fwd=%b rot=%b rdy=%b trp=%b step=%0d, want fwd=%b rot=%b rdy=%b trp=%b step=%0d",
                 cur_name, $time, mon_got[11], mon_got[10], mon_got[9], mon_got[8], mon_got[7:0],
                 mon_exp[11], mon_exp[10], mon_exp[9], mon_exp[8], mon_exp[7:0]);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic hold(input bit v, f, r, ct, rst, input logic [11:0] e);
    cmd_valid  = v;
    cmd_front  = f;
    cmd_rotate = r;
    clear_trap = ct;
    reset      = rst;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // kind: 0 = consumed without motion, 1 = forward, 2 = rotate
  task automatic send(input bit f, r, input int kind, input logic [7:0] step_before,
                      input logic [7:0] step_after, input bit trap_after);
    int len;
    len = (kind == 1) ? FWD_LEN : (kind == 2) ? ROT_LEN : 0;
    cmd_valid  = 1'b1;
    cmd_front  = f;
    cmd_rotate = r;
    clear_trap = 1'b0;
    for (int i = 0; i < len; i++)
      exp_q.push_back({(kind == 1), (kind == 2), 1'b0, 1'b0, step_before});
    exp_q.push_back({1'b0, 1'b0, ~trap_after, trap_after, step_after});
    for (int i = 0; i <= len; i++) begin
      @(negedge clk);
      if (i < len) begin
        cmd_valid  = 1'($urandom_range(0, 1));
        cmd_front  = 1'($urandom_range(0, 1));
        cmd_rotate = 1'($urandom_range(0, 1));
        clear_trap = 1'($urandom_range(0, 1));
      end else begin
        cmd_valid  = 1'b0;
        cmd_front  = 1'b0;
        cmd_rotate = 1'b0;
        clear_trap = 1'b0;
      end
    end
  endtask

  typedef struct {
    bit         f;
    bit         r;
    int         kind;
    logic [7:0] step_after;
    bit         trap_after;
  } vec_t;

  vec_t tbl[13];
  logic [7:0] prev_step;
  logic [7:0] sat_step;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1, 8'd1, 1'b0};  // forward
    tbl[1]  = '{1'b1, 1'b1, 2, 8'd1, 1'b0};  // both set: rotate wins
    tbl[2]  = '{1'b0, 1'b0, 0, 8'd1, 1'b0};  // null command consumed
    tbl[3]  = '{1'b0, 1'b1, 2, 8'd1, 1'b0};  // streak 2
    tbl[4]  = '{1'b1, 1'b0, 1, 8'd2, 1'b0};  // streak cleared
    tbl[5]  = '{1'b0, 1'b1, 2, 8'd2, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 2, 8'd2, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 2, 8'd2, 1'b0};  // streak 3
    tbl[8]  = '{1'b1, 1'b0, 1, 8'd3, 1'b0};  // streak cleared
    tbl[9]  = '{1'b0, 1'b1, 2, 8'd3, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 2, 8'd3, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 2, 8'd3, 1'b0};  // streak 3, not trapped
    tbl[12] = '{1'b0, 1'b1, 2, 8'd3, 1'b1};  // fourth in a row: trapped

    @(negedge clk);
    @(negedge clk);
    hold(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {4'b0010, 8'd0});
    hold(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {4'b0010, 8'd0});

    cur_name = "table";
    prev_step = 8'd0;
    for (int i = 0; i < 13; i++) begin
      send(tbl[i].f, tbl[i].r, tbl[i].kind, prev_step, tbl[i].step_after, tbl[i].trap_after);
      prev_step = tbl[i].step_after;
    end

    cur_name = "trapped_ignores_cmd";
    hold(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {4'b0001, 8'd3});
    hold(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, {4'b0001, 8'd3});
    hold(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, {4'b0001, 8'd3});
    cur_name = "clear_beats_cmd";
    hold(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, {4'b0010, 8'd3});
    hold(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {4'b0010, 8'd3});

    cur_name = "streak_cleared_by_clear";
    send(1'b0, 1'b1, 2, 8'd3, 8'd3, 1'b0);
    send(1'b0, 1'b1, 2, 8'd3, 8'd3, 1'b0);
    send(1'b0, 1'b1, 2, 8'd3, 8'd3, 1'b0);

    cur_name = "reset_mid_fwd";
    hold(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {4'b1000, 8'd3});
    hold(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {4'b1000, 8'd3});
    hold(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {4'b0010, 8'd0});
    hold(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {4'b0010, 8'd0});

    cur_name = "saturation";
    for (int i = 0; i < 260; i++) begin
      prev_step = (i > 255) ? 8'd255 : 8'(i);
      sat_step  = (i >= 255) ? 8'd255 : 8'(i + 1);
      send(1'b1, 1'b0, 1, prev_step, sat_step, 1'b0);
    end
    cur_name = "null_cmd";
    send(1'b0, 1'b0, 0, 8'd255, 8'd255, 1'b0);
    hold(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {4'b0010, 8'd255});

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
